// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station: opcode encodings, RoB tag width,
// RS index width, entry layout and the broadcast snoop helper.
package reservation_station_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned ROB_ADDR_W = 4;
    localparam int unsigned RS_IDX_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5,
        OP_SLL  = 6'd6,
        OP_SRL  = 6'd7,
        OP_SRA  = 6'd8,
        OP_SLT  = 6'd9,
        OP_SLTU = 6'd10
    } alu_op_e;

    typedef struct packed {
        logic                  busy;
        logic [OP_W-1:0]       op;
        logic [XLEN-1:0]       vj;
        logic [XLEN-1:0]       vk;
        logic [ROB_ADDR_W-1:0] qj;
        logic [ROB_ADDR_W-1:0] qk;
        logic                  qj_busy;
        logic                  qk_busy;
        logic [ROB_ADDR_W-1:0] robid;
    } rs_entry_t;

    typedef struct packed {
        logic            busy;
        logic [XLEN-1:0] val;
    } operand_t;

    // ALU broadcast wins when both buses carry the awaited tag.
    function automatic operand_t snoop(
        input operand_t              cur,
        input logic [ROB_ADDR_W-1:0] tag,
        input logic                  alu_v,
        input logic [ROB_ADDR_W-1:0] alu_tag,
        input logic [XLEN-1:0]       alu_val,
        input logic                  lsb_v,
        input logic [ROB_ADDR_W-1:0] lsb_tag,
        input logic [XLEN-1:0]       lsb_val
    );
        operand_t res;
        res = cur;
        if (cur.busy && alu_v && (alu_tag == tag)) begin
            res.busy = 1'b0;
            res.val  = alu_val;
        end else if (cur.busy && lsb_v && (lsb_tag == tag)) begin
            res.busy = 1'b0;
            res.val  = lsb_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Issue selector: one-hot grant over eligible entries. With RS_OLDEST_FIRST_EN the
// entry with the highest age rank wins, otherwise the lowest index wins.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]          eligible,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [N*RS_IDX_W-1:0] ages,
`endif
    output logic [N-1:0]          grant,
    output logic                  valid
);

    assign valid = |eligible;

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_IDX_W-1:0] best_age;
    logic                found;

    always_comb begin
        grant    = '0;
        best_age = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i] && (!found || (ages[i*RS_IDX_W +: RS_IDX_W] > best_age))) begin
                grant    = '0;
                grant[i] = 1'b1;
                best_age = ages[i*RS_IDX_W +: RS_IDX_W];
                found    = 1'b1;
            end
        end
    end
`else
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/reservation_station.sv
// Reservation station: dispatch into lowest free slot, tag wakeup from ALU/LSB
// broadcasts, one registered issue per cycle. Macro RS_OLDEST_FIRST_EN selects oldest-first.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  dispatch_valid,
    input  logic [OP_W-1:0]       dispatch_op,
    input  logic [XLEN-1:0]       dispatch_vj,
    input  logic [XLEN-1:0]       dispatch_vk,
    input  logic                  dispatch_qj_busy,
    input  logic                  dispatch_qk_busy,
    input  logic [ROB_ADDR_W-1:0] dispatch_qj,
    input  logic [ROB_ADDR_W-1:0] dispatch_qk,
    input  logic [ROB_ADDR_W-1:0] dispatch_robid,
    input  logic                  alu_valid,
    input  logic [ROB_ADDR_W-1:0] alu_robid,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  lsb_valid,
    input  logic [ROB_ADDR_W-1:0] lsb_robid,
    input  logic [XLEN-1:0]       lsb_result,
    output logic                  rs_full,
    output logic [OP_W-1:0]       issue_op,
    output logic [XLEN-1:0]       issue_rs1,
    output logic [XLEN-1:0]       issue_rs2,
    output logic [ROB_ADDR_W-1:0] issue_robid
);

    localparam int unsigned SEL_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    rs_entry_t             entries    [RS_SIZE];
    rs_entry_t             entries_nx [RS_SIZE];
    rs_entry_t             new_entry;
    operand_t              opj, opk;
    logic [RS_SIZE-1:0]    busy_vec, eligible, grant;
    logic                  sel_valid, do_dispatch;
    logic [SEL_W-1:0]      sel_idx, free_idx;
    logic [OP_W-1:0]       op_nx;
    logic [XLEN-1:0]       rs1_nx, rs2_nx;
    logic [ROB_ADDR_W-1:0] robid_nx;

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i] = entries[i].busy;
            eligible[i] = entries[i].busy && !entries[i].qj_busy && !entries[i].qk_busy;
        end
    end

    assign rs_full     = &busy_vec;
    assign do_dispatch = dispatch_valid && !rs_full;

    always_comb begin
        free_idx = '0;
        for (int unsigned i = RS_SIZE; i > 0; i--) begin
            if (!busy_vec[i-1]) free_idx = SEL_W'(i - 1);
        end
        sel_idx = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) sel_idx = SEL_W'(i);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // Age is a rank: number of younger busy entries, so it stays below RS_SIZE.
    logic [RS_IDX_W-1:0]         ages    [RS_SIZE];
    logic [RS_IDX_W-1:0]         ages_nx [RS_SIZE];
    logic [RS_SIZE*RS_IDX_W-1:0] ages_flat;

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ages_flat[i*RS_IDX_W +: RS_IDX_W] = ages[i];
        end
    end

    always_comb begin
        ages_nx = ages;
        if (!clear && rdy_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (entries[i].busy) begin
                    ages_nx[i] = ages[i] + RS_IDX_W'(do_dispatch)
                               - RS_IDX_W'(sel_valid && (ages[i] > ages[sel_idx]));
                end
            end
            if (do_dispatch) ages_nx[free_idx] = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) ages[i] <= '0;
        end else begin
            ages <= ages_nx;
        end
    end

    rs_select #(.N(RS_SIZE)) u_select (
        .eligible (eligible),
        .ages     (ages_flat),
        .grant    (grant),
        .valid    (sel_valid)
    );
`else
    rs_select #(.N(RS_SIZE)) u_select (
        .eligible (eligible),
        .grant    (grant),
        .valid    (sel_valid)
    );
`endif

    always_comb begin
        opj = snoop({dispatch_qj_busy, dispatch_vj}, dispatch_qj,
                    alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
        opk = snoop({dispatch_qk_busy, dispatch_vk}, dispatch_qk,
                    alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.op      = dispatch_op;
        new_entry.vj      = opj.val;
        new_entry.vk      = opk.val;
        new_entry.qj      = dispatch_qj;
        new_entry.qk      = dispatch_qk;
        new_entry.qj_busy = opj.busy;
        new_entry.qk_busy = opk.busy;
        new_entry.robid   = dispatch_robid;
    end

    // Selection uses start-of-cycle state, so the issued entry is freed before any write to it.
    always_comb begin
        entries_nx = entries;
        op_nx      = '0;
        rs1_nx     = issue_rs1;
        rs2_nx     = issue_rs2;
        robid_nx   = issue_robid;
        if (clear) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) entries_nx[i].busy = 1'b0;
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (entries[i].busy) begin
                    {entries_nx[i].qj_busy, entries_nx[i].vj} =
                        snoop({entries[i].qj_busy, entries[i].vj}, entries[i].qj,
                              alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
                    {entries_nx[i].qk_busy, entries_nx[i].vk} =
                        snoop({entries[i].qk_busy, entries[i].vk}, entries[i].qk,
                              alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
                end
            end
            if (sel_valid) begin
                op_nx                    = entries[sel_idx].op;
                rs1_nx                   = entries[sel_idx].vj;
                rs2_nx                   = entries[sel_idx].vk;
                robid_nx                 = entries[sel_idx].robid;
                entries_nx[sel_idx].busy = 1'b0;
            end
            if (do_dispatch) entries_nx[free_idx] = new_entry;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) entries[i] <= '0;
            issue_op    <= '0;
            issue_rs1   <= '0;
            issue_rs2   <= '0;
            issue_robid <= '0;
        end else begin
            entries     <= entries_nx;
            issue_op    <= op_nx;
            issue_rs1   <= rs1_nx;
            issue_rs2   <= rs2_nx;
            issue_robid <= robid_nx;
        end
    end

endmodule
